aer_core_merger: RTL and testbench

// - Reverse path of the input-AER-to-core fan-out mapper: collects output spike events from the CORE_W*CORE_H core array and serialises them onto one output AER link.
// - Rebuilds the global feature-map address {type, c, core_y, core_x} from the winning core's index and its local neuron index.
// - Merges per-core non-neuron events (e.g. end-of-timestep) into one output event, emitted once every core has reported it.

---
 rtl/snn_aer_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/aer_core_merger.sv | 172 +++++++++++++++++
 tb/tb_aer_core_merger.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/snn_aer_pkg.sv
// Shared AER definitions: event type encoding and type extraction helper.
package snn_aer_pkg;

  typedef enum logic [1:0] {
    SPIKE   = 2'b00,
    NN_A    = 2'b01,
    NN_B    = 2'b10,
    INVALID = 2'b11
  } aer_type_e;

  // Decode the two type bits taken from the top of an event word.
  function automatic aer_type_e aer_type(input logic [1:0] hdr);
    return aer_type_e'(hdr);
  endfunction

  function automatic logic is_non_neuron(input aer_type_e t);
    return (t == NN_A) || (t == NN_B);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned N  = 256,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          valid
);

  always_comb begin
    int unsigned idx;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!valid && req[PW'(idx)]) begin
        valid = 1'b1;
        grant = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/aer_core_merger.sv
// Serialises per-core output AER events onto one link, rebuilding global addresses
// and merging per-core non-neuron events into a single event once all cores report.
module aer_core_merger
  import snn_aer_pkg::*;
#(
  parameter int unsigned CORE_W         = 16,
  parameter int unsigned CORE_H         = 16,
  parameter int unsigned CORE_C         = 3,
  parameter int unsigned CORE_AER_WIDTH = 12,
  parameter int unsigned OUT_AER_WIDTH  = 12
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [CORE_W*CORE_H-1:0]                     CORE_AEROUT_REQ,
  input  logic [CORE_W*CORE_H-1:0][CORE_AER_WIDTH-1:0] CORE_AEROUT_EVENT,
  output logic [CORE_W*CORE_H-1:0]                     CORE_AEROUT_ACK,
  output logic                                         MERGE_AEROUT_REQ,
  output logic [OUT_AER_WIDTH-1:0]                     MERGE_AEROUT_EVENT,
  input  logic                                         MERGE_AEROUT_ACK,
  output logic                                         MERGE_ERR_INVALID
);

  localparam int unsigned N      = CORE_W * CORE_H;
  localparam int unsigned PTR_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned C_BITS = (CORE_C > 1) ? $clog2(CORE_C) : 1;
  localparam int unsigned X_BITS = (CORE_W > 1) ? $clog2(CORE_W) : 1;
  localparam int unsigned Y_BITS = (CORE_H > 1) ? $clog2(CORE_H) : 1;

  if (OUT_AER_WIDTH < 2 + C_BITS + Y_BITS + X_BITS) begin : g_width_chk
    $error("aer_core_merger: OUT_AER_WIDTH too narrow for type+neuron+y+x");
  end

  typedef enum logic [2:0] {
    IDLE, OUT_REQ, OUT_REL, COLLECT, CORE_ACK
  } state_e;

  state_e                 state, state_nxt;
  logic [PTR_W-1:0]       rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]       win, win_nxt;
  aer_type_e              win_type, win_type_nxt;
  logic [N-1:0]           done_mask, mask_nxt, mask_set;
  aer_type_e              pend_type, pend_nxt;
  logic                   merging, merging_nxt;
  logic [OUT_AER_WIDTH-1:0] out_ev_nxt, spike_ev, merged_ev;
  logic                   err_nxt;
  logic [N-1:0]           elig;
  logic [PTR_W-1:0]       grant;
  logic                   grant_valid;
  aer_type_e              grant_type;
  logic                   mask_any;
  logic                   unused_evt_bits;

  assign unused_evt_bits = ^CORE_AEROUT_EVENT;
  assign mask_any = |done_mask;

  // A core is eligible unless it already reported this round, or it offers a
  // non-neuron type that differs from the one being collected.
  for (genvar i = 0; i < N; i++) begin : g_elig
    aer_type_e t;
    assign t = aer_type(CORE_AEROUT_EVENT[i][CORE_AER_WIDTH-1 -: 2]);
    assign elig[i] = CORE_AEROUT_REQ[i]
                   && !(done_mask[i] && (t != INVALID))
                   && !(mask_any && is_non_neuron(t) && (t != pend_type));
  end

  rr_arbiter #(.N(N), .PW(PTR_W)) u_arb (
    .req   (elig),
    .ptr   (rr_ptr),
    .grant (grant),
    .valid (grant_valid)
  );

  assign grant_type = aer_type(CORE_AEROUT_EVENT[grant][CORE_AER_WIDTH-1 -: 2]);
  assign mask_set   = done_mask | (N'(1) << win);

  // Output event images: rebuilt spike address, and merged non-neuron event.
  always_comb begin
    spike_ev = '0;
    spike_ev[OUT_AER_WIDTH-1 -: 2]      = SPIKE;
    spike_ev[X_BITS+Y_BITS +: C_BITS]   = CORE_AEROUT_EVENT[grant][C_BITS-1:0];
    spike_ev[X_BITS +: Y_BITS]          = Y_BITS'(32'(grant) / CORE_W);
    spike_ev[0 +: X_BITS]               = X_BITS'(32'(grant) % CORE_W);
    merged_ev = '1;
    merged_ev[OUT_AER_WIDTH-1 -: 2]     = win_type;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    win_nxt      = win;
    win_type_nxt = win_type;
    mask_nxt     = done_mask;
    pend_nxt     = pend_type;
    merging_nxt  = merging;
    out_ev_nxt   = MERGE_AEROUT_EVENT;
    err_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          win_nxt      = grant;
          win_type_nxt = grant_type;
          rr_ptr_nxt   = (32'(grant) == N - 1) ? '0 : PTR_W'(32'(grant) + 1);
          unique case (grant_type)
            SPIKE: begin
              state_nxt  = OUT_REQ;
              out_ev_nxt = spike_ev;
            end
            NN_A, NN_B: state_nxt = COLLECT;
            default: begin
              state_nxt = CORE_ACK;
              err_nxt   = 1'b1;
            end
          endcase
        end
      end
      COLLECT: begin
        mask_nxt = mask_set;
        pend_nxt = win_type;
        if (&mask_set) begin
          state_nxt   = OUT_REQ;
          merging_nxt = 1'b1;
          out_ev_nxt  = merged_ev;
        end else begin
          state_nxt = CORE_ACK;
        end
      end
      OUT_REQ: if (MERGE_AEROUT_ACK) state_nxt = OUT_REL;
      OUT_REL: begin
        if (!MERGE_AEROUT_ACK) begin
          state_nxt = CORE_ACK;
          if (merging) begin
            mask_nxt    = '0;
            merging_nxt = 1'b0;
          end
        end
      end
      CORE_ACK: if (!CORE_AEROUT_REQ[win]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      win                <= '0;
      win_type           <= SPIKE;
      done_mask          <= '0;
      pend_type          <= SPIKE;
      merging            <= 1'b0;
      CORE_AEROUT_ACK    <= '0;
      MERGE_AEROUT_REQ   <= 1'b0;
      MERGE_AEROUT_EVENT <= '0;
      MERGE_ERR_INVALID  <= 1'b0;
    end else begin
      state              <= state_nxt;
      rr_ptr             <= rr_ptr_nxt;
      win                <= win_nxt;
      win_type           <= win_type_nxt;
      done_mask          <= mask_nxt;
      pend_type          <= pend_nxt;
      merging            <= merging_nxt;
      CORE_AEROUT_ACK    <= (state_nxt == CORE_ACK) ? (N'(1) << win_nxt) : '0;
      MERGE_AEROUT_REQ   <= (state_nxt == OUT_REQ);
      MERGE_AEROUT_EVENT <= out_ev_nxt;
      MERGE_ERR_INVALID  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_aer_core_merger.sv
// Directed self-checking bench for aer_core_merger with a 16x16 core array.
module tb_aer_core_merger;

  localparam int unsigned N = 256;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         core_req;
  logic [N-1:0][11:0]   core_ev;
  logic [N-1:0]         core_ack;
  logic                 m_req;
  logic [11:0]          m_ev;
  logic                 m_ack;
  logic                 m_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aer_core_merger dut (
    .clk                (clk),
    .rst                (rst),
    .CORE_AEROUT_REQ    (core_req),
    .CORE_AEROUT_EVENT  (core_ev),
    .CORE_AEROUT_ACK    (core_ack),
    .MERGE_AEROUT_REQ   (m_req),
    .MERGE_AEROUT_EVENT (m_ev),
    .MERGE_AEROUT_ACK   (m_ack),
    .MERGE_ERR_INVALID  (m_err)
  );

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle; cores drop REQ as soon as they see their ACK.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) if (core_ack[i]) core_req[i] = 1'b0;
  endtask

  task automatic serve_merge(input int hold, input int bound, output logic [11:0] ev);
    int n;
    n = 0;
    while (!m_req && n < bound) begin tick(); n++; end
    check("merge_req_seen", N'(m_req), N'(1));
    ev = m_ev;
    check("core_ack_quiet_during_req", core_ack, '0);
    repeat (hold) tick();
    m_ack = 1'b1;
    n = 0;
    do begin tick(); n++; end while (m_req && n < bound);
    check("merge_req_drop", N'(m_req), '0);
    m_ack = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((core_req != '0 || core_ack != '0 || m_req) && n < bound) begin tick(); n++; end
    check("idle_reached", core_req | core_ack | N'(m_req), '0);
  endtask

  initial begin
    logic [11:0]  ev;
    logic [N-1:0] exp_ack;
    int           n;
    int           req_cnt;

    core_req = '0;
    core_ev  = '0;
    m_ack    = 1'b0;
    rst      = 1'b1;
    repeat (3) tick();
    check("rst_merge_req", N'(m_req), '0);
    check("rst_merge_ev", N'(m_ev), '0);
    check("rst_core_ack", core_ack, '0);
    check("rst_err", N'(m_err), '0);
    rst = 1'b0;
    tick();

    // Core 17 spike, neuron 2, downstream ack after 2 cycles
    core_ev[17]  = 12'h002;
    core_req[17] = 1'b1;
    tick();
    check("t1_req_latency", N'(m_req), N'(1));
    check("t1_event", N'(m_ev), N'(12'h211));
    check("t1_no_core_ack", core_ack, '0);
    tick(); tick();
    check("t1_req_held", N'(m_req), N'(1));
    check("t1_core_ack_held_off", core_ack, '0);
    m_ack = 1'b1;
    tick();
    check("t1_req_released", N'(m_req), '0);
    check("t1_core_ack_still_off", core_ack, '0);
    m_ack = 1'b0;
    tick();
    exp_ack = '0;
    exp_ack[17] = 1'b1;
    check("t1_core_ack17", core_ack, exp_ack);
    tick();
    check("t1_core_ack_drop", core_ack, '0);
    wait_idle(20);

    // Move rr_ptr to 3 via core 2, then cores 0, 5, 255 together
    core_req[2] = 1'b1;
    serve_merge(1, 20, ev);
    check("t2_core2", N'(ev), N'(12'h002));
    wait_idle(20);
    core_req[0] = 1'b1; core_req[5] = 1'b1; core_req[255] = 1'b1;
    serve_merge(0, 20, ev);
    check("t2_first_5", N'(ev), N'(12'h005));
    serve_merge(2, 20, ev);
    check("t2_second_255", N'(ev), N'(12'h0FF));
    serve_merge(0, 20, ev);
    check("t2_third_0", N'(ev), N'(12'h000));
    wait_idle(20);
    // rr_ptr should now be 1: core 1 wins over core 0
    core_req[0] = 1'b1; core_req[1] = 1'b1;
    serve_merge(0, 20, ev);
    check("t2_ptr1_core1_first", N'(ev), N'(12'h001));
    serve_merge(0, 20, ev);
    check("t2_ptr1_core0_next", N'(ev), N'(12'h000));
    wait_idle(20);

    // All cores report type 01; core 3 follows up with a spike
    for (int i = 0; i < N; i++) core_ev[i] = 12'h400;
    core_req = '1;
    n = 0;
    while ((core_req[3] || core_ack[3]) && n < 200) begin tick(); n++; end
    check("t3_core3_reported", N'(core_req[3] | core_ack[3]), '0);
    core_ev[3]  = 12'h001;
    core_req[3] = 1'b1;
    serve_merge(1, 3000, ev);
    check("t3_merged_event", N'(ev), N'(12'h7FF));
    check("t3_mask_full", dut.done_mask, '1);
    serve_merge(0, 50, ev);
    check("t3_core3_spike_after", N'(ev), N'(12'h103));
    check("t3_mask_cleared", dut.done_mask, '0);
    wait_idle(20);

    // Invalid event from core 9 is dropped with an error pulse
    core_ev[9]  = 12'hC00;
    core_req[9] = 1'b1;
    tick();
    exp_ack = '0;
    exp_ack[9] = 1'b1;
    check("t4_err_pulse", N'(m_err), N'(1));
    check("t4_core_ack9", core_ack, exp_ack);
    check("t4_no_merge_req", N'(m_req), '0);
    tick();
    check("t4_err_single", N'(m_err), '0);
    check("t4_no_merge_req2", N'(m_req), '0);
    wait_idle(20);

    // Reset while downstream ack is pending
    core_ev[20]  = 12'h000;
    core_req[20] = 1'b1;
    tick();
    check("t5_req_up", N'(m_req), N'(1));
    rst = 1'b1;
    tick();
    check("t5_rst_req", N'(m_req), '0);
    check("t5_rst_ev", N'(m_ev), '0);
    check("t5_rst_ack", core_ack, '0);
    check("t5_rst_err", N'(m_err), '0);
    rst = 1'b0;
    serve_merge(0, 20, ev);
    check("t5_reemit", N'(ev), N'(12'h014));
    wait_idle(20);
    req_cnt = 0;
    repeat (10) begin tick(); if (m_req) req_cnt++; end
    check("t5_emitted_once", N'(req_cnt), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
